vscale_hasti_bridge_pipe: RTL and testbench
===========================================

Name: vscale_hasti_bridge_pipe

Overview:
Parametrised, phase-tracking successor to the core-to-HASTI (AHB-Lite) master bridge. It sits between the vscale core data-memory port and the HASTI bus. The block registers data-phase state so that write data is lane-replicated and read data is lane-extracted for 32- or 64-bit buses. It also blocks misaligned requests before they reach the bus, implements the two-cycle AHB ERROR response, and keeps a saturating error counter.

Parameters:
ADDR_WIDTH, 32, haddr/core address width
BUS_WIDTH, 32, HASTI data width; legal values 32 or 64; LANE_BITS = log2(BUS_WIDTH/8)
ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
haddr  output  ADDR_WIDTH  address-phase address (= core_mem_addr)
hwrite  output  1  core_mem_en & core_mem_wen & issue
hsize  output  3  = core_mem_size
hburst  output  3  constant SINGLE
hmastlock  output  1  constant 0
hprot  output  4  constant NO_PROT
htrans  output  2  NONSEQ when issue, else IDLE
hwdata  output  BUS_WIDTH  data-phase write data, lane-replicated
hrdata  input  BUS_WIDTH  bus read data
hready  input  1  slave ready
hresp  input  1  OKAY=0, ERROR=1
core_mem_en  input  1  core request valid
core_mem_wen  input  1  request is write
core_mem_size  input  3  0=byte, 1=half, 2=word, 3=dword (dword only if BUS_WIDTH=64)
core_mem_addr  input  ADDR_WIDTH  request address
core_mem_wdata_delayed  input  BUS_WIDTH  write data, right-aligned, valid in data phase
core_mem_rdata  output  BUS_WIDTH  read data, right-aligned, zero-extended
core_mem_wait  output  1  stall core
core_badmem_e  output  1  one-cycle pulse: bus error completed
core_misaligned  output  1  combinational: current request misaligned or illegal size
err_count  output  ERR_CNT_WIDTH  saturating count of completed error responses

Behaviour:
- States: IDLE (no data phase), DATA (data phase outstanding), ERR (first ERROR cycle seen).
- misaligned = core_mem_en & (addr[size-1:0] != 0 for size>=1, or size > LANE_BITS).
- issue = core_mem_en & ~misaligned & (state != ERR). Misaligned requests never reach the bus: htrans IDLE, no state change.
- Address accepted at the clk edge when issue & hready. Data-phase register loads {write, size, addr[LANE_BITS-1:0]}. Next state is DATA.
- DATA:
  - hready=1, hresp=OKAY: transfer completes. Next state is DATA if a new issue is accepted in the same cycle (back-to-back pipelining), else IDLE.
  - hready=0, hresp=ERROR: go to ERR. The address presented in that cycle is not accepted.
  - hready=0, hresp=OKAY: hold.
- ERR:
  - htrans forced IDLE.
  - On hready=1 & hresp=ERROR: core_badmem_e=1 for that cycle, err_count increments (saturates at all-ones), go to IDLE.
  - hready=1 with OKAY in ERR is a protocol violation; treat it identically.
- core_mem_wait = (state==DATA & ~hready) | (state==ERR) | (core_mem_en & ~misaligned & ~hready).
- hwdata, driven from the data-phase register:
  - byte: low byte replicated to every lane.
  - half: low 16 bits replicated.
  - word: low 32 replicated (64-bit bus).
  - dword: passthrough.
- core_mem_rdata = hrdata >> (8*registered lane offset), masked to the registered size, zero-extended. Valid only in the completing data-phase cycle. Sign extension is the core's job.
- Reset (async, any time including mid-transfer):
  - state IDLE, data-phase register cleared, err_count 0.
  - core_badmem_e 0, core_mem_wait 0, htrans IDLE (core_mem_en is 0 during reset).
  - An outstanding transfer is abandoned without handshake.
- Latency: a zero-wait read returns data one cycle after address acceptance. Constant outputs are never X.

Test Plan:
- BUS_WIDTH=32, read size=2 addr 0x100, hrdata=0xDEADBEEF, hready=1 -> htrans NONSEQ cycle 0; core_mem_rdata=0xDEADBEEF cycle 1; wait=0 throughout.
- Byte write addr 0x103, wdata 0x000000A5 -> hwdata=0xA5A5A5A5 in data phase. Byte read addr 0x102, hrdata 0x11223344 -> rdata=0x00000022.
- Half read addr 0x101 -> core_misaligned=1, htrans IDLE, state unchanged, err_count 0.
- Back-to-back reads 0x0, 0x4 with 2 wait states on the first -> wait=1 for 2 cycles; second address held and accepted on first hready=1; both rdata correct in order.
- Write with hresp ERROR/hready 0 then ERROR/hready 1 -> htrans IDLE during ERR; core_badmem_e pulses exactly once; err_count 0->1. Repeat 300 times with ERR_CNT_WIDTH=8 -> saturates at 255.
- BUS_WIDTH=64, dword read addr 0x8 -> full 64-bit rdata. Assert reset mid-DATA -> outputs return to reset values immediately; next request proceeds normally.

Source files
------------

// File: rtl/vscale_hasti_bridge_pipe.sv
// Core data-memory port to HASTI (AHB-Lite) master bridge with data-phase
// tracking, lane replication/extraction, misalignment blocking, two-cycle
// ERROR handling and a saturating bus-error counter.
module vscale_hasti_bridge_pipe #(
  parameter int ADDR_WIDTH    = 32,
  parameter int BUS_WIDTH     = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_WIDTH-1:0]    haddr,
  output logic                     hwrite,
  output logic [2:0]               hsize,
  output logic [2:0]               hburst,
  output logic                     hmastlock,
  output logic [3:0]               hprot,
  output logic [1:0]               htrans,
  output logic [BUS_WIDTH-1:0]     hwdata,
  input  logic [BUS_WIDTH-1:0]     hrdata,
  input  logic                     hready,
  input  logic                     hresp,
  input  logic                     core_mem_en,
  input  logic                     core_mem_wen,
  input  logic [2:0]               core_mem_size,
  input  logic [ADDR_WIDTH-1:0]    core_mem_addr,
  input  logic [BUS_WIDTH-1:0]     core_mem_wdata_delayed,
  output logic [BUS_WIDTH-1:0]     core_mem_rdata,
  output logic                     core_mem_wait,
  output logic                     core_badmem_e,
  output logic                     core_misaligned,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  localparam int LANE_BITS = $clog2(BUS_WIDTH/8);
  localparam int NB        = BUS_WIDTH/8;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR} state_e;
  typedef struct packed {
    logic                 wr;
    logic [2:0]           size;
    logic [LANE_BITS-1:0] off;
  } dphase_t;

  state_e                  state_q, state_d;
  dphase_t                 dp_q, dp_d, dp_new;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   amask;
  logic                    misaligned, issue, accept;
  logic [BUS_WIDTH-1:0]    rshift, rmask;

  // low address bits that must be zero for the requested size
  assign amask      = ~({ADDR_WIDTH{1'b1}} << core_mem_size);
  assign misaligned = core_mem_en &
                      ((32'(core_mem_size) > LANE_BITS) | ((core_mem_addr & amask) != '0));
  assign issue      = core_mem_en & ~misaligned & (state_q != S_ERR);
  assign accept     = issue & hready;
  assign dp_new     = '{wr: core_mem_wen, size: core_mem_size,
                        off: core_mem_addr[LANE_BITS-1:0]};

  assign haddr           = core_mem_addr;
  assign hsize           = core_mem_size;
  assign hwrite          = core_mem_en & core_mem_wen & issue;
  assign htrans          = issue ? 2'b10 : 2'b00;
  assign hburst          = 3'b000;
  assign hmastlock       = 1'b0;
  assign hprot           = 4'b0000;
  assign core_misaligned = misaligned;
  assign err_count       = cnt_q;
  assign core_mem_wait   = ((state_q == S_DATA) & ~hready) | (state_q == S_ERR) |
                           (core_mem_en & ~misaligned & ~hready);

  // phase tracking, data-phase capture and error accounting
  always_comb begin
    state_d       = state_q;
    dp_d          = dp_q;
    cnt_d         = cnt_q;
    core_badmem_e = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_DATA;
        dp_d    = dp_new;
      end
      S_DATA: begin
        if (hready) begin
          state_d = accept ? S_DATA : S_IDLE;
          if (accept) dp_d = dp_new;
        end else if (hresp) begin
          state_d = S_ERR;
        end
      end
      S_ERR: if (hready) begin
        // second ERROR cycle (or a slave that dropped hresp early) ends it
        core_badmem_e = 1'b1;
        state_d       = S_IDLE;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dp_q    <= dp_d;
      cnt_q   <= cnt_d;
    end
  end

  // write data replicated across lanes by the registered size
  always_comb begin
    case (dp_q.size)
      3'd0:    hwdata = {NB{core_mem_wdata_delayed[7:0]}};
      3'd1:    hwdata = {(NB/2){core_mem_wdata_delayed[15:0]}};
      3'd2:    hwdata = {(NB/4){core_mem_wdata_delayed[31:0]}};
      default: hwdata = core_mem_wdata_delayed;
    endcase
  end

  // read data: shift the addressed lane down, then zero the bytes above size
  assign rshift = hrdata >> {dp_q.off, 3'b000};
  always_comb begin
    case (dp_q.size)
      3'd0:    rmask = BUS_WIDTH'(8'hFF);
      3'd1:    rmask = BUS_WIDTH'(16'hFFFF);
      3'd2:    rmask = BUS_WIDTH'(32'hFFFF_FFFF);
      default: rmask = '1;
    endcase
  end
  assign core_mem_rdata = rshift & rmask;
endmodule

// File: tb/tb_vscale_hasti_bridge_pipe.sv
// Random stimulus on a 32-bit and a 64-bit bridge, each checked every cycle
// against a transaction-level model of the bus phases.
module tb_vscale_hasti_bridge_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        en[2], wen[2], hready[2], hresp[2];
  logic [2:0]  size[2];
  logic [31:0] addr[2];
  logic [63:0] wd[2], hrd[2];

  logic [31:0] haddr_o[2];
  logic        hwrite_o[2], hmastlock_o[2], wait_o[2], bad_o[2], mis_o[2];
  logic [2:0]  hsize_o[2], hburst_o[2];
  logic [3:0]  hprot_o[2];
  logic [1:0]  htrans_o[2];
  logic [7:0]  cnt_o[2];
  logic [31:0] hw0, rd0;
  logic [63:0] hw1, rd1;

  vscale_hasti_bridge_pipe #(.ADDR_WIDTH(32), .BUS_WIDTH(32), .ERR_CNT_WIDTH(8)) u_b32 (
    .clk(clk), .reset(reset), .haddr(haddr_o[0]), .hwrite(hwrite_o[0]), .hsize(hsize_o[0]),
    .hburst(hburst_o[0]), .hmastlock(hmastlock_o[0]), .hprot(hprot_o[0]), .htrans(htrans_o[0]),
    .hwdata(hw0), .hrdata(hrd[0][31:0]), .hready(hready[0]), .hresp(hresp[0]),
    .core_mem_en(en[0]), .core_mem_wen(wen[0]), .core_mem_size(size[0]), .core_mem_addr(addr[0]),
    .core_mem_wdata_delayed(wd[0][31:0]), .core_mem_rdata(rd0), .core_mem_wait(wait_o[0]),
    .core_badmem_e(bad_o[0]), .core_misaligned(mis_o[0]), .err_count(cnt_o[0]));

  vscale_hasti_bridge_pipe #(.ADDR_WIDTH(32), .BUS_WIDTH(64), .ERR_CNT_WIDTH(8)) u_b64 (
    .clk(clk), .reset(reset), .haddr(haddr_o[1]), .hwrite(hwrite_o[1]), .hsize(hsize_o[1]),
    .hburst(hburst_o[1]), .hmastlock(hmastlock_o[1]), .hprot(hprot_o[1]), .htrans(htrans_o[1]),
    .hwdata(hw1), .hrdata(hrd[1]), .hready(hready[1]), .hresp(hresp[1]),
    .core_mem_en(en[1]), .core_mem_wen(wen[1]), .core_mem_size(size[1]), .core_mem_addr(addr[1]),
    .core_mem_wdata_delayed(wd[1]), .core_mem_rdata(rd1), .core_mem_wait(wait_o[1]),
    .core_badmem_e(bad_o[1]), .core_misaligned(mis_o[1]), .err_count(cnt_o[1]));

  // model: phase 0 = no data phase, 1 = data phase outstanding, 2 = first ERROR seen
  int   ph[2], dsize[2], doff[2], cnt[2];
  logic dwr[2];
  int   nchk = 0, nerr = 0, cur_k = 0;
  logic rst_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d t=%0t got %h exp %h", tag, cur_k, $time, obs, exp);
    end
  endtask

  function automatic int lanes_log2(input int k);
    return (k != 0) ? 3 : 2;
  endfunction

  function automatic logic mis_f(input int k);
    int sz;
    sz = int'(size[k]);
    return en[k] && ((sz > lanes_log2(k)) || ((addr[k] % (32'd1 << sz)) != 0));
  endfunction

  function automatic logic iss_f(input int k);
    return en[k] && !mis_f(k) && (ph[k] != 2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; dsize[k] = 0; doff[k] = 0; cnt[k] = 0; dwr[k] = 1'b0;
    end
  endtask

  task automatic step(input int k);
    logic acc;
    acc = iss_f(k) && hready[k];
    if (ph[k] == 2) begin
      if (hready[k]) begin
        ph[k] = 0;
        if (cnt[k] < 255) cnt[k]++;
      end
    end else if (ph[k] == 1 && !hready[k]) begin
      if (hresp[k]) ph[k] = 2;
    end else begin
      ph[k] = acc ? 1 : 0;
      if (acc) begin
        dwr[k] = wen[k]; dsize[k] = int'(size[k]);
        doff[k] = int'(addr[k] % ((k != 0) ? 8 : 4));
      end
    end
  endtask

  task automatic check_all(input int k);
    logic mis, iss;
    logic [63:0] exp, hwo, rdo;
    int nb, lb;
    lb = lanes_log2(k); nb = 1 << lb;
    mis = mis_f(k); iss = iss_f(k);
    hwo = (k != 0) ? hw1 : {32'b0, hw0};
    rdo = (k != 0) ? rd1 : {32'b0, rd0};
    cur_k = k;
    chk("misaligned", 64'(mis_o[k]), 64'(mis));
    chk("htrans", 64'(htrans_o[k]), iss ? 64'd2 : 64'd0);
    chk("hwrite", 64'(hwrite_o[k]), 64'(iss && wen[k]));
    chk("haddr", 64'(haddr_o[k]), 64'(addr[k]));
    chk("hsize", 64'(hsize_o[k]), 64'(size[k]));
    chk("hconst", 64'({hburst_o[k], hmastlock_o[k], hprot_o[k]}), 64'd0);
    chk("wait", 64'(wait_o[k]),
        64'((ph[k] == 1 && !hready[k]) || ph[k] == 2 || (en[k] && !mis && !hready[k])));
    chk("badmem", 64'(bad_o[k]), 64'(ph[k] == 2 && hready[k]));
    chk("err_count", 64'(cnt_o[k]), 64'(cnt[k]));
    if (ph[k] == 1 && dwr[k]) begin
      exp = '0;
      for (int i = 0; i < nb; i++) exp[8*i +: 8] = wd[k][8*(i % (1 << dsize[k])) +: 8];
      chk("hwdata", hwo, exp);
    end
    if (ph[k] == 1 && hready[k] && !dwr[k]) begin
      exp = hrd[k] >> (8 * doff[k]);
      if (dsize[k] < lb) exp = exp & ((64'd1 << (8 << dsize[k])) - 64'd1);
      else if (nb == 4) exp = exp & 64'hFFFF_FFFF;
      chk("rdata", rdo, exp);
    end
  endtask

  task automatic drive(input int k, input logic sat);
    int r, lb;
    lb = lanes_log2(k);
    wd[k]  = (k != 0) ? {$urandom, $urandom} : {32'b0, $urandom};
    hrd[k] = (k != 0) ? {$urandom, $urandom} : {32'b0, $urandom};
    if (sat) begin
      en[k] = 1'b1; wen[k] = 1'b1; size[k] = 3'd2;
      addr[k] = $urandom & 32'h0000_0FFC;
      hready[k] = (ph[k] != 1);
      hresp[k]  = (ph[k] != 0);
    end else begin
      en[k]  = ($urandom_range(0, 9) < 7);
      wen[k] = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      size[k] = (r < 9) ? 3'($urandom_range(0, lb)) : 3'($urandom_range(lb + 1, 7));
      addr[k] = $urandom_range(0, 63);
      case (ph[k])
        0: begin hready[k] = ($urandom_range(0, 9) < 8); hresp[k] = 1'b0; end
        1: begin
          r = $urandom_range(0, 9);
          hready[k] = (r < 6);
          hresp[k]  = (r >= 8);
        end
        default: begin
          hready[k] = 1'($urandom_range(0, 1));
          hresp[k]  = ($urandom_range(0, 3) != 0);
        end
      endcase
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; wen[k] = 1'b0; hready[k] = 1'b1; hresp[k] = 1'b0;
      size[k] = 3'd0; addr[k] = '0; wd[k] = '0; hrd[k] = '0;
    end
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) check_all(k);

    for (int cyc = 0; cyc < 2600; cyc++) begin
      @(posedge clk);
      #1;
      if (!reset) for (int k = 0; k < 2; k++) step(k);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) drive(k, cyc >= 1500);
      #2;
      for (int k = 0; k < 2; k++) check_all(k);
      // abandon an in-flight data phase with an asynchronous reset
      if (!rst_done && cyc >= 600 && ph[0] == 1) begin
        reset = 1'b1;
        en[0] = 1'b0; en[1] = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) check_all(k);
        rst_done = 1'b1;
      end
    end

    #2;
    cur_k = 0; chk("err_sat", 64'(cnt_o[0]), 64'd255);
    cur_k = 1; chk("err_sat", 64'(cnt_o[1]), 64'd255);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
